omsp_spm_key_writer: RTL and testbench

//  Initiator side of the SPM key-write interface: loads a freshly derived module key into one SPM.

---
 rtl/omsp_spm_key_writer_pkg.sv | 26 ++
 rtl/omsp_spm_key_fold.sv | 17 +
 rtl/omsp_spm_key_writer.sv | 188 ++++++++++++++++++
 tb/tb_omsp_spm_key_writer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/omsp_spm_key_writer_pkg.sv
// Shared types and sizing for the SPM key writer and its fold helper.
package omsp_spm_key_writer_pkg;

    localparam int unsigned SECURITY_W = 64;

    localparam int unsigned WORD_W    = 16;
    localparam int unsigned KEY_WORDS = SECURITY_W / WORD_W;
    localparam int unsigned CNT_W     = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;

    // Key-writer sequencing states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_VERIFY = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // One key-word write towards spm_control
    typedef struct packed {
        logic [CNT_W-1:0]  idx;
        logic [WORD_W-1:0] word;
    } key_wr_t;

endpackage

// File: rtl/omsp_spm_key_fold.sv
// Combinational XOR-fold of the full SPM key down to one 16-bit word.
module omsp_spm_key_fold
    import omsp_spm_key_writer_pkg::*;
(
    input  logic [SECURITY_W-1:0] i_key,
    output logic [WORD_W-1:0]     o_fold_c
);

    // XOR every 16-bit slice of the key together
    always_comb begin
        o_fold_c = '0;
        for (int unsigned i = 0; i < KEY_WORDS; i++) begin
            o_fold_c = o_fold_c ^ i_key[i*WORD_W +: WORD_W];
        end
    end

endmodule

// File: rtl/omsp_spm_key_writer.sv
// SPM key writer: streams a derived key from the crypto unit into the
// selected SPM through spm_control, then reports done/error.
// Optional build macro SPM_KEY_READBACK_EN adds a post-load checksum
// verification of key_out before reporting done.
module omsp_spm_key_writer
    import omsp_spm_key_writer_pkg::*;
#(
    parameter int unsigned KEY_IDX_SIZE = 4
)(
    input  logic                    mclk,
    input  logic                    puc_rst_n,
    input  logic                    start,
    input  logic [15:0]             target_id,
    input  logic                    abort,
    input  logic                    word_valid,
    input  logic [15:0]             word_in,
    output logic                    word_ready,
    output logic [15:0]             spm_key_select,
    input  logic                    spm_key_select_valid,
    output logic                    write_key,
    output logic [15:0]             key_in,
    output logic [KEY_IDX_SIZE-1:0] key_idx,
    input  logic [SECURITY_W-1:0]   key_out,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(KEY_WORDS - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] r_sel;
    key_wr_t           r_wr;
    logic              r_write_key;
    logic              r_word_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic              w_hs;
    logic              w_last;
    logic              w_done_next;
    logic              w_error_next;
    logic              w_mismatch;

`ifdef SPM_KEY_READBACK_EN
    logic [WORD_W-1:0] r_chk;
    logic [WORD_W-1:0] w_fold;

    omsp_spm_key_fold u_fold (
        .i_key    (key_out),
        .o_fold_c (w_fold)
    );

    assign w_mismatch = (r_chk != w_fold);

    // Running XOR of accepted words, cleared whenever the writer returns to idle
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            r_chk <= '0;
        end else if (w_next_state == ST_IDLE) begin
            r_chk <= '0;
        end else if (w_hs) begin
            r_chk <= r_chk ^ word_in;
        end
    end
`else
    logic w_unused_key_out;
    assign w_unused_key_out = ^key_out;
    assign w_mismatch       = 1'b0;
`endif

    // State register
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, handshake and completion decode
    always_comb begin
        w_next_state = r_state;
        w_hs         = 1'b0;
        w_done_next  = 1'b0;
        w_error_next = 1'b0;
        w_last       = (r_cnt == LAST_IDX);
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (!spm_key_select_valid) begin
                    w_next_state = ST_IDLE;
                    w_error_next = 1'b1;
                end else begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (word_valid && r_word_ready) begin
                    w_hs = 1'b1;
                    if (w_last) begin
                        w_next_state = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else begin
`ifdef SPM_KEY_READBACK_EN
                    w_next_state = ST_VERIFY;
`else
                    w_next_state = ST_DONE;
                    w_done_next  = 1'b1;
`endif
                end
            end
            ST_VERIFY: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DONE;
                    w_error_next = w_mismatch;
                    w_done_next  = !w_mismatch;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, word counter and target select
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            r_write_key  <= 1'b0;
            r_wr         <= '0;
            r_word_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_sel        <= '0;
            r_cnt        <= '0;
        end else begin
            r_write_key  <= w_hs;
            r_word_ready <= (w_next_state == ST_LOAD);
            r_busy       <= (w_next_state != ST_IDLE);
            r_done       <= w_done_next;
            r_error      <= w_error_next;
            if (w_hs) begin
                r_wr <= {r_cnt, word_in};
            end
            if (w_next_state == ST_IDLE) begin
                r_sel <= '0;
            end else if (r_state == ST_IDLE) begin
                r_sel <= target_id;
            end
            if (w_next_state == ST_IDLE) begin
                r_cnt <= '0;
            end else if (w_hs && !w_last) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign word_ready     = r_word_ready;
    assign spm_key_select = r_sel;
    assign write_key      = r_write_key;
    assign key_in         = r_wr.word;
    assign key_idx        = KEY_IDX_SIZE'(r_wr.idx);
    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_error;

endmodule

// File: tb/tb_omsp_spm_key_writer.sv
// Scoreboard bench for omsp_spm_key_writer (64-bit key, 4 words).
module tb_omsp_spm_key_writer;
    import omsp_spm_key_writer_pkg::*;

    localparam int KW = 4;
`ifdef SPM_KEY_READBACK_EN
    localparam bit RB       = 1'b1;
    localparam int DONE_LAT = 2;
`else
    localparam bit RB       = 1'b0;
    localparam int DONE_LAT = 1;
`endif
    localparam int EV_DONE    = 0;
    localparam int EV_ERR_SEL = 1;
    localparam int EV_ERR_RB  = 2;

    logic        mclk = 1'b0;
    logic        puc_rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] target_id = '0;
    logic        abort = 1'b0;
    logic        word_valid = 1'b0;
    logic [15:0] word_in = '0;
    logic        word_ready;
    logic [15:0] spm_key_select;
    logic        spm_key_select_valid;
    logic        write_key;
    logic [15:0] key_in;
    logic [3:0]  key_idx;
    logic [SECURITY_W-1:0] key_out;
    logic        busy;
    logic        done;
    logic        error;

    omsp_spm_key_writer #(.KEY_IDX_SIZE(4)) dut (
        .mclk                 (mclk),
        .puc_rst_n            (puc_rst_n),
        .start                (start),
        .target_id            (target_id),
        .abort                (abort),
        .word_valid           (word_valid),
        .word_in              (word_in),
        .word_ready           (word_ready),
        .spm_key_select       (spm_key_select),
        .spm_key_select_valid (spm_key_select_valid),
        .write_key            (write_key),
        .key_in               (key_in),
        .key_idx              (key_idx),
        .key_out              (key_out),
        .busy                 (busy),
        .done                 (done),
        .error                (error)
    );

    always #5 mclk = ~mclk;

    // SPM control model: one enabled ID, key storage written on each strobe
    logic [15:0] enabled_id = 16'h0;
    logic        corrupt = 1'b0;
    logic [15:0] mem [KW];
    assign spm_key_select_valid = (spm_key_select != 16'h0) && (spm_key_select == enabled_id);
    assign key_out = corrupt ? '0 : {mem[3], mem[2], mem[1], mem[0]};
    always @(posedge mclk) if (write_key) mem[key_idx[1:0]] <= key_in;

    typedef struct { int idx; logic [15:0] word; } wr_t;
    wr_t wq[$];
    int  eq[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int last_wr_cyc = 0;
    bit mon_en = 1'b1;
    logic [15:0] exp_sel = '0;
    logic [15:0] words [KW];
    wr_t m_w;
    int  m_ev;

    always @(posedge mclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop expectations whenever the DUT presents a write or a completion
    always @(negedge mclk) begin
        if (mon_en && puc_rst_n) begin
            if (write_key) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 64'(write_key), 64'd0);
                end else begin
                    m_w = wq.pop_front();
                    chk("key_idx", 64'(key_idx), 64'(m_w.idx));
                    chk("key_in", 64'(key_in), 64'(m_w.word));
                    chk("select_during_write", 64'(spm_key_select), 64'(exp_sel));
                end
                last_wr_cyc = cyc;
            end
            if (done || error) begin
                if (eq.size() == 0) begin
                    chk("unexpected_done_error", 64'({done, error}), 64'd0);
                end else begin
                    m_ev = eq.pop_front();
                    chk("event_kind", 64'({done, error}), (m_ev == EV_DONE) ? 64'd2 : 64'd1);
                    if (m_ev == EV_ERR_SEL)
                        chk("select_error_latency", 64'(cyc - start_cyc), 64'd2);
                    else
                        chk("completion_latency", 64'(cyc - last_wr_cyc), 64'(DONE_LAT));
                end
            end
        end
    end

    task automatic drain_checks();
        int w;
        for (w = 0; w < 40; w++) begin
            @(negedge mclk);
            if (!busy) break;
        end
        if (busy) chk("idle_timeout", 64'(busy), 64'd0);
        repeat (2) @(posedge mclk);
        #1;
        chk("events_drained", 64'(eq.size()), 64'd0);
        chk("writes_drained", 64'(wq.size()), 64'd0);
        chk("select_zero_idle", 64'(spm_key_select), 64'd0);
    endtask

    // action: 0 full load, 1 abort after cut words, 2 reset after cut words
    task automatic run_load(input logic [15:0] tgt, input bit sel_ok, input int mode,
                            input int action, input int cut, input bit corrupt_rb);
        int n;
        int sent;
        int guard;
        bit hs;
        bit v;
        logic [15:0] x;
        n = (action == 0) ? KW : cut;
        enabled_id = sel_ok ? tgt : ~tgt;
        exp_sel = tgt;
        corrupt = corrupt_rb;
        mon_en = (action != 2);
        if (action != 2) begin
            if (!sel_ok) begin
                eq.push_back(EV_ERR_SEL);
            end else begin
                x = '0;
                for (int i = 0; i < n; i++) begin
                    wq.push_back('{i, words[i]});
                    x = x ^ words[i];
                end
                if (action == 0)
                    eq.push_back((RB && corrupt_rb && (x != 16'h0)) ? EV_ERR_RB : EV_DONE);
            end
        end
        start = 1'b1;
        target_id = tgt;
        start_cyc = cyc;
        @(posedge mclk);
        #1;
        start = 1'b0;
        target_id = 16'($urandom);
        sent = 0;
        guard = 0;
        while (sel_ok && sent < n && guard < 200) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = ((guard % 2) == 0);
                default: v = 1'($urandom_range(1));
            endcase
            word_valid = v;
            word_in = v ? words[sent] : 16'($urandom);
            start = ($urandom_range(3) == 0);
            target_id = 16'($urandom);
            @(negedge mclk);
            hs = word_valid && word_ready;
            @(posedge mclk);
            #1;
            if (hs) sent++;
            guard++;
        end
        start = 1'b0;
        word_valid = 1'b0;
        if (sel_ok) chk("handshake_count", 64'(sent), 64'(n));
        if (action == 1) begin
            abort = 1'b1;
            @(posedge mclk);
            #1;
            abort = 1'b0;
            @(negedge mclk);
            chk("abort_busy_low", 64'(busy), 64'd0);
            chk("abort_ready_low", 64'(word_ready), 64'd0);
        end else if (action == 2) begin
            puc_rst_n = 1'b0;
            #1;
            chk("rst_write_key", 64'(write_key), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_word_ready", 64'(word_ready), 64'd0);
            chk("rst_select", 64'(spm_key_select), 64'd0);
            chk("rst_key_idx_in", 64'({key_idx, key_in}), 64'd0);
            chk("rst_done_error", 64'({done, error}), 64'd0);
            @(posedge mclk);
            #1;
            puc_rst_n = 1'b1;
            wq.delete();
            eq.delete();
        end
        drain_checks();
        corrupt = 1'b0;
        mon_en = 1'b1;
    endtask

    initial begin
        #3 puc_rst_n = 1'b0;
        #1;
        chk("reset_outputs", 64'({word_ready, write_key, busy, done, error}), 64'd0);
        chk("reset_select", 64'(spm_key_select), 64'd0);
        chk("reset_key", 64'({key_idx, key_in}), 64'd0);
        @(posedge mclk);
        #1;
        puc_rst_n = 1'b1;
        repeat (2) @(posedge mclk);
        #1;

        // Directed back-to-back load
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
        run_load(16'h0003, 1'b1, 0, 0, 0, 1'b0);
        // Invalid target
        run_load(16'h0005, 1'b0, 0, 0, 0, 1'b0);
        // Alternating word_valid
        words[0] = 16'hA5A5; words[1] = 16'h0F0F; words[2] = 16'h1234; words[3] = 16'hFEDC;
        run_load(16'h0007, 1'b1, 1, 0, 0, 1'b0);
        // Abort after two words
        run_load(16'h0009, 1'b1, 0, 1, 2, 1'b0);
        // key_out forced to zero after load
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
        run_load(16'h000B, 1'b1, 0, 0, 0, 1'b1);

        // start together with abort in IDLE is ignored
        start = 1'b1; abort = 1'b1; target_id = 16'h0011;
        @(posedge mclk);
        #1;
        start = 1'b0; abort = 1'b0;
        @(negedge mclk);
        chk("start_abort_busy", 64'(busy), 64'd0);
        chk("start_abort_select", 64'(spm_key_select), 64'd0);

        // word_valid in IDLE is never acknowledged
        @(posedge mclk);
        #1;
        word_valid = 1'b1; word_in = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge mclk);
            chk("idle_word_ready", 64'(word_ready), 64'd0);
        end
        @(posedge mclk);
        #1;
        word_valid = 1'b0;

        // Reset mid-load, then a clean reload from index 0
        run_load(16'h0013, 1'b1, 0, 2, 2, 1'b0);
        run_load(16'h0013, 1'b1, 0, 0, 0, 1'b0);

        // Randomized transactions
        for (int t = 0; t < 25; t++) begin
            bit ok;
            int act;
            for (int i = 0; i < KW; i++) words[i] = 16'($urandom);
            ok  = ($urandom_range(9) < 8);
            act = ok ? $urandom_range(2) : 0;
            if (act == 2) act = 0;
            run_load(16'($urandom_range(16'hFFFF, 1)), ok, $urandom_range(2), act,
                     $urandom_range(KW - 1), 1'($urandom_range(1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit (total=%0d bad=%0d)", total, bad);
        $fatal(1);
    end

endmodule
